// File: rtl/centroid_ctrl_if.sv
// ============================================================================
// Module      : centroid_ctrl_if
// Description : Video-in / centroid-out bundle of the centroid engine.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface centroid_ctrl_if;
  logic        de;
  logic        vsync;
  logic        mask_in;
  logic [10:0] x_center;
  logic [10:0] y_center;
  logic        centroid_valid;
  logic        frame_empty;
  logic        frame_drop;
  logic        busy;

  modport master (
    output de, vsync, mask_in,
    input  x_center, y_center, centroid_valid, frame_empty, frame_drop, busy
  );

  modport slave (
    input  de, vsync, mask_in,
    output x_center, y_center, centroid_valid, frame_empty, frame_drop, busy
  );
endinterface

`default_nettype wire

// File: rtl/centroid_ctrl.sv
// ============================================================================
// Module      : centroid_ctrl
// Description : Per-frame mask centroid: moment accumulation + shared divider.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module centroid_ctrl #(
  parameter int IMG_W    = 1280,
  parameter int IMG_H    = 720,
  parameter int MIN_AREA = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  centroid_ctrl_if.slave bus
);

  localparam logic [10:0] X_LAST   = 11'(IMG_W - 1);
  localparam logic [9:0]  Y_LAST   = 10'(IMG_H - 1);
  localparam logic [19:0] MIN_AREA_C = 20'(MIN_AREA);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_DIV_X  = 3'd2,
    S_DIV_Y  = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        vs_q, vs_d;
  logic [10:0] x_pos_q, x_pos_d;
  logic [9:0]  y_pos_q, y_pos_d;
  logic [19:0] m00_q, m00_d, snap_m00_q, snap_m00_d;
  logic [31:0] m10_q, m10_d, snap_m10_q, snap_m10_d;
  logic [31:0] m01_q, m01_d, snap_m01_q, snap_m01_d;
  logic [31:0] dq_q, dq_d, qx_q, qx_d;
  logic [19:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [10:0] x_center_q, x_center_d, y_center_q, y_center_d;

  logic        fe;
  logic [20:0] m00_sum;
  logic [32:0] m10_sum, m01_sum;
  logic [20:0] rem_sh;
  logic        q_bit;
  logic [19:0] rem_nx;
  logic [31:0] q_nx;

  function automatic logic [10:0] clamp(input logic [31:0] q, input logic [10:0] lim);
    return (q > {21'd0, lim}) ? lim : q[10:0];
  endfunction

  assign fe      = bus.vsync && !vs_q;
  assign m00_sum = {1'b0, m00_q} + 21'd1;
  assign m10_sum = {1'b0, m10_q} + 33'(x_pos_q);
  assign m01_sum = {1'b0, m01_q} + 33'(y_pos_q);

  // One restoring step: the dividend shifts out of dq while quotient bits shift in.
  assign rem_sh = {rem_q, dq_q[31]};
  assign q_bit  = (rem_sh >= {1'b0, snap_m00_q});
  assign rem_nx = q_bit ? (rem_sh[19:0] - snap_m00_q) : rem_sh[19:0];
  assign q_nx   = {dq_q[30:0], q_bit};

  always_comb begin
    state_d    = state_q;
    vs_d       = bus.vsync;
    x_pos_d    = x_pos_q;
    y_pos_d    = y_pos_q;
    m00_d      = m00_q;
    m10_d      = m10_q;
    m01_d      = m01_q;
    snap_m00_d = snap_m00_q;
    snap_m10_d = snap_m10_q;
    snap_m01_d = snap_m01_q;
    dq_d       = dq_q;
    qx_d       = qx_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    x_center_d = x_center_q;
    y_center_d = y_center_q;

    if (bus.vsync) begin
      x_pos_d = '0;
      y_pos_d = '0;
    end else if (bus.de) begin
      if (x_pos_q == X_LAST) begin
        x_pos_d = '0;
        y_pos_d = (y_pos_q == Y_LAST) ? '0 : y_pos_q + 10'd1;
      end else begin
        x_pos_d = x_pos_q + 11'd1;
      end
    end

    if (fe) begin
      if (state_q == S_IDLE) begin
        snap_m00_d = m00_q;
        snap_m10_d = m10_q;
        snap_m01_d = m01_q;
      end
      m00_d = '0;
      m10_d = '0;
      m01_d = '0;
    end else if (bus.de && bus.mask_in && !bus.vsync) begin
      m00_d = m00_sum[20] ? '1 : m00_sum[19:0];
      m10_d = m10_sum[32] ? '1 : m10_sum[31:0];
      m01_d = m01_sum[32] ? '1 : m01_sum[31:0];
    end

    case (state_q)
      S_IDLE: begin
        if (fe) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (snap_m00_q < MIN_AREA_C) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DIV_X;
          dq_d    = snap_m10_q;
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      S_DIV_X: begin
        dq_d  = q_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DIV_Y;
          qx_d    = q_nx;
          dq_d    = snap_m01_q;
          rem_d   = '0;
        end
      end
      S_DIV_Y: begin
        dq_d  = q_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + 5'd1;
        // Load the outputs on the last step so they change in the UPDATE cycle.
        if (cnt_q == 5'd31) begin
          state_d    = S_UPDATE;
          x_center_d = clamp(qx_q, X_LAST);
          y_center_d = clamp(q_nx, {1'b0, Y_LAST});
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      vs_q       <= 1'b0;
      x_pos_q    <= '0;
      y_pos_q    <= '0;
      m00_q      <= '0;
      m10_q      <= '0;
      m01_q      <= '0;
      snap_m00_q <= '0;
      snap_m10_q <= '0;
      snap_m01_q <= '0;
      dq_q       <= '0;
      qx_q       <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      x_center_q <= '0;
      y_center_q <= '0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vs_d;
      x_pos_q    <= x_pos_d;
      y_pos_q    <= y_pos_d;
      m00_q      <= m00_d;
      m10_q      <= m10_d;
      m01_q      <= m01_d;
      snap_m00_q <= snap_m00_d;
      snap_m10_q <= snap_m10_d;
      snap_m01_q <= snap_m01_d;
      dq_q       <= dq_d;
      qx_q       <= qx_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      x_center_q <= x_center_d;
      y_center_q <= y_center_d;
    end
  end

  assign bus.x_center       = x_center_q;
  assign bus.y_center       = y_center_q;
  assign bus.centroid_valid = (state_q == S_UPDATE);
  assign bus.frame_empty    = (state_q == S_CHECK) && (snap_m00_q < MIN_AREA_C);
  assign bus.frame_drop     = fe && (state_q != S_IDLE);
  assign bus.busy           = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_centroid_ctrl.sv
// ============================================================================
// Module      : tb_centroid_ctrl
// Description : Directed self-checking bench for centroid_ctrl (8x4 and 64x32 frames).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_centroid_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  centroid_ctrl_if vif ();
  centroid_ctrl_if vif2 ();

  centroid_ctrl #(.IMG_W(8), .IMG_H(4), .MIN_AREA(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif.slave)
  );

  centroid_ctrl #(.IMG_W(64), .IMG_H(32), .MIN_AREA(1)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif2.slave)
  );

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;
  logic rst_drv = 1'b0;
  int rel, valid_at, valid_cnt, empty_at, empty_cnt, drop_at, drop_cnt, busy_cnt;

  logic [10:0] o_x, o_y;
  logic        o_valid, o_empty, o_drop, o_busy;
  assign o_x     = sel ? vif2.x_center       : vif.x_center;
  assign o_y     = sel ? vif2.y_center       : vif.y_center;
  assign o_valid = sel ? vif2.centroid_valid : vif.centroid_valid;
  assign o_empty = sel ? vif2.frame_empty    : vif.frame_empty;
  assign o_drop  = sel ? vif2.frame_drop     : vif.frame_drop;
  assign o_busy  = sel ? vif2.busy           : vif.busy;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive after the rising edge, observe at the falling edge.
  task automatic cyc(input logic d, input logic v, input logic m, input bit mark);
    @(posedge clk);
    #1;
    rst_n = rst_drv;
    if (!sel) begin
      vif.de = d; vif.vsync = v; vif.mask_in = m;
    end else begin
      vif2.de = d; vif2.vsync = v; vif2.mask_in = m;
    end
    if (mark) begin
      rel = -1; valid_at = -1; valid_cnt = 0; empty_at = -1; empty_cnt = 0;
      drop_at = -1; drop_cnt = 0; busy_cnt = 0;
    end
    @(negedge clk);
    rel++;
    if (o_valid) begin valid_at = rel; valid_cnt++; end
    if (o_empty) begin empty_at = rel; empty_cnt++; end
    if (o_drop)  begin drop_at = rel; drop_cnt++; end
    if (o_busy)  busy_cnt++;
  endtask

  // 8x4 frame (bit x of row y = mask), closed by a marked frame-end cycle.
  task automatic send_frame(input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3);
    logic [7:0] rows [4];
    rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        cyc(1'b1, 1'b0, rows[y][x], 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic tail(input int n);
    for (int r = 1; r <= n; r++) cyc(1'b0, (r <= 2), 1'b0, 1'b0);
  endtask

  initial begin
    vif.de = 1'b0;  vif.vsync = 1'b0;  vif.mask_in = 1'b0;
    vif2.de = 1'b0; vif2.vsync = 1'b0; vif2.mask_in = 1'b0;
    rel = 0; valid_at = -1; valid_cnt = 0; empty_at = -1; empty_cnt = 0;
    drop_at = -1; drop_cnt = 0; busy_cnt = 0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_x", o_x, 0);
    chk("rst_y", o_y, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_empty", o_empty, 0);
    chk("rst_drop", o_drop, 0);
    chk("rst_busy", o_busy, 0);
    rst_drv = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Single pixel at (3,2)
    send_frame(8'h00, 8'h00, 8'h08, 8'h00);
    tail(80);
    chk("t1_valid_at", valid_at, 66);
    chk("t1_valid_cnt", valid_cnt, 1);
    chk("t1_busy_cnt", busy_cnt, 66);
    chk("t1_x", o_x, 3);
    chk("t1_y", o_y, 2);
    chk("t1_empty_cnt", empty_cnt, 0);

    // Empty frame holds the previous result
    send_frame(8'h00, 8'h00, 8'h00, 8'h00);
    tail(80);
    chk("t2_empty_at", empty_at, 1);
    chk("t2_empty_cnt", empty_cnt, 1);
    chk("t2_valid_cnt", valid_cnt, 0);
    chk("t2_busy_cnt", busy_cnt, 1);
    chk("t2_x", o_x, 3);
    chk("t2_y", o_y, 2);

    // Block x=2..5, y=1..2: floor(28/8)=3, floor(12/8)=1
    send_frame(8'h00, 8'h3C, 8'h3C, 8'h00);
    tail(80);
    chk("t3_valid_at", valid_at, 66);
    chk("t3_x", o_x, 3);
    chk("t3_y", o_y, 1);

    // Second frame end at fe+20 while dividing is dropped
    send_frame(8'h00, 8'h00, 8'h08, 8'h00);
    for (int r = 1; r <= 80; r++)
      cyc((r >= 5 && r <= 15), (r <= 2) || (r >= 20 && r <= 21), (r >= 5 && r <= 15), 1'b0);
    chk("t4_drop_at", drop_at, 20);
    chk("t4_drop_cnt", drop_cnt, 1);
    chk("t4_valid_at", valid_at, 66);
    chk("t4_x", o_x, 3);
    chk("t4_y", o_y, 2);
    send_frame(8'h00, 8'h3C, 8'h3C, 8'h00);
    tail(80);
    chk("t4n_valid_at", valid_at, 66);
    chk("t4n_x", o_x, 3);
    chk("t4n_y", o_y, 1);

    // Frame end coinciding with UPDATE
    send_frame(8'h00, 8'h00, 8'h08, 8'h00);
    for (int r = 1; r <= 80; r++)
      cyc(1'b0, (r <= 2) || (r >= 66 && r <= 67), 1'b0, 1'b0);
    chk("t5_drop_at", drop_at, 66);
    chk("t5_valid_at", valid_at, 66);
    chk("t5_busy_cnt", busy_cnt, 66);
    chk("t5_x", o_x, 3);
    chk("t5_y", o_y, 2);

    // Reset at fe+40 aborts the division
    send_frame(8'h00, 8'h3C, 8'h3C, 8'h00);
    for (int r = 1; r <= 39; r++) cyc(1'b0, (r <= 2), 1'b0, 1'b0);
    rst_drv = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_rst_busy", o_busy, 0);
    chk("t6_rst_x", o_x, 0);
    chk("t6_rst_y", o_y, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst_drv = 1'b1;
    tail(40);
    chk("t6_no_pulse", valid_cnt, 0);
    send_frame(8'h00, 8'h00, 8'h08, 8'h00);
    tail(80);
    chk("t6_valid_at", valid_at, 66);
    chk("t6_x", o_x, 3);
    chk("t6_y", o_y, 2);

    // 64x32 all-ones: floor(64512/2048)=31, floor(31744/2048)=15
    sel = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64 * 32; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    tail(80);
    chk("t7_valid_at", valid_at, 66);
    chk("t7_x", o_x, 31);
    chk("t7_y", o_y, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
